// File: rtl/median_stream_if.sv
// Pixel stream bundle for the median stage: upstream pixel handshake plus
// the filtered-pixel handshake towards the Sobel stage.
interface median_stream_if;
    logic [7:0] pixel_in;
    logic       in_valid;
    logic       in_sof;
    logic       in_ready;
    logic [7:0] pixel_out;
    logic       out_valid;
    logic       out_ready;
    logic       out_eof;

    modport master (
        output pixel_in, in_valid, in_sof, out_ready,
        input  in_ready, pixel_out, out_valid, out_eof
    );

    modport slave (
        input  pixel_in, in_valid, in_sof, out_ready,
        output in_ready, pixel_out, out_valid, out_eof
    );
endinterface

// File: rtl/median_stream.sv
// Streaming 3x3 median filter: two line buffers feed a sliding 3x3 window,
// border pixels pass through, and the last WIDTH+1 outputs drain from the buffers.
module median_stream #(
    parameter int WIDTH  = 512,
    parameter int HEIGHT = 512
) (
    input  logic           clock,
    input  logic           reset,
    median_stream_if.slave strm,
    output logic           doneFlag
);

    localparam int COL_W = $clog2(WIDTH);
    localparam int ROW_W = $clog2(HEIGHT);
    localparam int FC_W  = $clog2(WIDTH + 2);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

    state_e           state_q, state_d;
    logic [COL_W-1:0] in_col_q, in_col_d;
    logic [ROW_W-1:0] in_row_q, in_row_d;
    logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [7:0]       pix_out_q, pix_out_d;
    logic             out_valid_q, out_valid_d;
    logic             out_eof_q, out_eof_d;
    logic             done_q;

    // Window columns, index 0 = oldest row, 2 = row currently arriving.
    logic [2:0][7:0]  col_old_q, col_new_q, col_in;
    logic [7:0]       lb_top_q [WIDTH];
    logic [7:0]       lb_mid_q [WIDTH];
    logic [COL_W-1:0] lb_top_addr, lb_mid_addr;
    logic [7:0]       lb_top_rd, lb_mid_rd;

    logic       in_ready_c, in_take, out_fire, last_in;
    logic       run_emit, run_border, flush_load;
    logic [7:0] window_med;

    // Rank selection: the element with exactly four smaller (ties broken by
    // position) is the 5th smallest.
    function automatic logic [7:0] median9(input logic [8:0][7:0] v);
        logic [7:0] med;
        logic [3:0] rank;
        med = v[0];
        for (int i = 0; i < 9; i++) begin
            rank = '0;
            for (int j = 0; j < 9; j++) begin
                if (j != i && (v[j] < v[i] || (v[j] == v[i] && j < i)))
                    rank = rank + 4'd1;
            end
            if (rank == 4'd4)
                med = v[i];
        end
        return med;
    endfunction

    assign in_take  = strm.in_valid & in_ready_c & ((state_q == RUN) | strm.in_sof);
    assign out_fire = out_valid_q & strm.out_ready;
    assign last_in  = (in_row_q == ROW_LAST) && (in_col_q == COL_LAST);

    // During the drain the top buffer holds (H-2, W-1) and the middle buffer the last row.
    assign lb_top_addr = (state_q == FLUSH) ? COL_LAST : in_col_q;
    assign lb_mid_addr = (state_q == FLUSH) ? COL_W'(flush_cnt_q - FC_W'(1)) : in_col_q;
    assign lb_top_rd   = lb_top_q[lb_top_addr];
    assign lb_mid_rd   = lb_mid_q[lb_mid_addr];
    assign col_in      = {strm.pixel_in, lb_mid_rd, lb_top_rd};
    assign window_med  = median9({col_old_q, col_new_q, col_in});

    // Output centre is (in_row-1, in_col-1); a column wrap lands on (in_row-2, WIDTH-1).
    assign run_emit   = (state_q == RUN) && in_take &&
                        ((in_row_q >= ROW_W'(2)) || (in_row_q == ROW_W'(1) && in_col_q != '0));
    assign run_border = (in_col_q <= COL_W'(1)) || (in_row_q == ROW_W'(1));
    assign flush_load = (state_q == FLUSH) && (flush_cnt_q <= FC_LAST) &&
                        (!out_valid_q || strm.out_ready);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_take) state_d = RUN;
            RUN:     if (in_take && last_in) state_d = FLUSH;
            FLUSH:   if (out_fire && out_eof_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready_c = 1'b0;
        if (reset) begin
            case (state_q)
                IDLE:    in_ready_c = 1'b1;
                RUN:     in_ready_c = !out_valid_q || strm.out_ready;
                default: in_ready_c = 1'b0;
            endcase
        end
    end

    always_comb begin
        // NOTE: every signal gets its hold value first so no path infers a latch.
        in_col_d    = in_col_q;
        in_row_d    = in_row_q;
        flush_cnt_d = flush_cnt_q;
        pix_out_d   = pix_out_q;
        out_valid_d = out_valid_q;
        out_eof_d   = out_eof_q;
        if (in_take) begin
            if (in_col_q == COL_LAST) begin
                in_col_d = '0;
                in_row_d = (in_row_q == ROW_LAST) ? '0 : in_row_q + ROW_W'(1);
            end else begin
                in_col_d = in_col_q + COL_W'(1);
            end
        end
        if (out_fire) begin
            out_valid_d = 1'b0;
            out_eof_d   = 1'b0;
        end
        if (run_emit) begin
            pix_out_d   = run_border ? col_new_q[1] : window_med;
            out_valid_d = 1'b1;
            out_eof_d   = 1'b0;
        end
        if (flush_load) begin
            pix_out_d   = (flush_cnt_q == '0) ? lb_top_rd : lb_mid_rd;
            out_valid_d = 1'b1;
            out_eof_d   = (flush_cnt_q == FC_LAST);
            flush_cnt_d = flush_cnt_q + FC_W'(1);
        end
        if (out_fire && out_eof_q)
            flush_cnt_d = '0;
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            in_col_q    <= '0;
            in_row_q    <= '0;
            flush_cnt_q <= '0;
            pix_out_q   <= '0;
            out_valid_q <= 1'b0;
            out_eof_q   <= 1'b0;
            done_q      <= 1'b0;
            col_old_q   <= '0;
            col_new_q   <= '0;
        end else begin
            in_col_q    <= in_col_d;
            in_row_q    <= in_row_d;
            flush_cnt_q <= flush_cnt_d;
            pix_out_q   <= pix_out_d;
            out_valid_q <= out_valid_d;
            out_eof_q   <= out_eof_d;
            done_q      <= out_fire & out_eof_q;
            if (in_take) begin
                col_old_q <= col_new_q;
                col_new_q <= col_in;
            end
        end
    end

    // NOTE: line buffers carry no reset; each row is rewritten before any median reads it.
    always_ff @(posedge clock) begin
        if (in_take) begin
            lb_top_q[in_col_q] <= lb_mid_rd;
            lb_mid_q[in_col_q] <= strm.pixel_in;
        end
    end

    assign strm.in_ready  = in_ready_c;
    assign strm.pixel_out = pix_out_q;
    assign strm.out_valid = out_valid_q;
    assign strm.out_eof   = out_eof_q;
    assign doneFlag       = done_q;

endmodule

// File: doc/median_stream.md
Name: median_stream

Overview:
- Streaming 3x3 median filter that sits directly upstream of the Sobel edge stage.
- Accepts one 8-bit greyscale pixel per handshake in raster order and emits the median-filtered frame in raster order.
- Border pixels pass through unfiltered.
- Replaces the whole-frame in-memory median pass: two line buffers plus a 3x3 window, no full-frame storage.

Parameters:
- WIDTH, 512, pixels per row (>=3)
- HEIGHT, 512, rows per frame (>=3)

Ports:
- clock  input  1  single system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- pixel_in  input  8  input pixel
- in_valid  input  1  pixel_in valid
- in_sof  input  1  marks first pixel (row 0, col 0) of a frame; qualified by in_valid
- in_ready  output  1  block can accept pixel_in this cycle
- pixel_out  output  8  filtered pixel
- out_valid  output  1  pixel_out valid
- out_ready  input  1  downstream accepts pixel_out
- out_eof  output  1  high with out_valid on last pixel (HEIGHT-1, WIDTH-1)
- doneFlag  output  1  one-cycle pulse after last output transfer

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; in_ready=0, out_valid=0, out_eof=0, doneFlag=0, pixel_out=0; all counters=0. Line-buffer contents are don't-care.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - pixel_out, out_valid and out_eof hold stable until the output transfer.
- State IDLE:
  - in_ready=1.
  - A transfer with in_sof=1 is pixel 0; store it and go to RUN.
  - A transfer with in_sof=0 is accepted and discarded.
- State RUN:
  - in_ready = !out_valid | out_ready (whole-pipeline stall).
  - Input index n = in_row*WIDTH+in_col, incremented per transfer, col wraps at WIDTH-1.
  - When input n is accepted and n >= WIDTH+1, output k = n-WIDTH-1 is registered: out_valid=1 on the next cycle.
  - in_sof=1 during RUN is ignored (treated as data).
  - After input n = WIDTH*HEIGHT-1 is accepted, go to FLUSH.
- State FLUSH:
  - in_ready=0.
  - Emit the remaining WIDTH+1 outputs, one per cycle, subject to out_ready.
  - The output transfer with out_eof=1 goes to IDLE and pulses doneFlag the following cycle.
- Output value for position (r,c):
  - r=0, r=HEIGHT-1, c=0 or c=WIDTH-1: the input pixel at (r,c) unchanged.
  - Otherwise: median (5th smallest) of the 9 input pixels at rows r-1..r+1, cols c-1..c+1.
  - Unsigned 8-bit compares; duplicates are counted individually.
  - The median network may be combinational into the pixel_out register; no arithmetic widening.
- Latency: with no stalls, output k appears one cycle after input k+WIDTH+1 is accepted. Total outputs per frame = WIDTH*HEIGHT exactly.
- Line buffers: two WIDTH x 8 memories, written at in_col and read-before-write in the same cycle. The window shifts one column per input transfer.
- Row wrap: window columns from the previous row must never contaminate an interior median. This is guaranteed because c=0 and c=WIDTH-1 are border pass-through.
- Stall: no state, counter or buffer changes on a cycle without an input transfer in RUN, or without an output transfer in FLUSH.
- Simultaneous events: in RUN, an output transfer and a new input transfer in the same cycle load the next output with no bubble.
- Reset mid-frame: partial frame abandoned, outputs drop to reset values immediately. The next in_sof starts a clean frame.
- out_eof=1 only for k = WIDTH*HEIGHT-1; doneFlag is never high with out_valid.

Test Plan:
- WIDTH=4, HEIGHT=4, all pixels 7, out_ready=1 -> 16 outputs all 7; out_eof on 16th; doneFlag pulses once; first out_valid one cycle after 6th input accepted.
- WIDTH=5, HEIGHT=5, all pixels 10 except (2,2)=255 -> all 25 outputs 10 (impulse removed); border values 10 unchanged.
- WIDTH=4, HEIGHT=4, pixel = index 0..15 -> output (1,1)=5, (1,2)=6, (2,1)=9, (2,2)=10; border outputs equal their index.
- Same ramp, out_ready toggling 1,0,0,1 pattern -> identical 16-value sequence; in_ready=0 whenever out_valid=1 & out_ready=0; no drops or duplicates.
- Reset asserted after 7th input of a 4x4 frame, then a full new frame of all 3 -> out_valid=0 immediately; second frame outputs 16 x 3 with correct out_eof and doneFlag.
- In IDLE, 3 pixels with in_sof=0 then a frame with in_sof on its first pixel -> first 3 discarded; frame output matches that frame only.
